// File: rtl/ym3438_dac_pkg.sv
// Shared constants and types for the YM3438 DAC accumulator.
package ym3438_dac_pkg;
  localparam logic [8:0] DAC_ZERO = 9'h100;
  localparam int ACC_W = 14;
  localparam int PCM_W = 16;
  localparam int CNT_W = 5;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    ACCUM     = 1'b1
  } dac_state_e;

  typedef struct packed {
    logic signed [PCM_W-1:0] l;
    logic signed [PCM_W-1:0] r;
  } pcm_sample_t;
endpackage

// File: rtl/ym3438_dac_acc_ch.sv
// One DAC channel: offset-binary conversion, slot accumulator, and an
// optional one-pole smoothing filter (enabled by YM3438_DAC_LPF_EN).
module ym3438_dac_acc_ch
  import ym3438_dac_pkg::*;
(
  input  logic                    MCLK,
  input  logic                    IC,
`ifdef YM3438_DAC_LPF_EN
  input  logic                    fin,
`endif
  input  logic                    load,
  input  logic                    add,
  input  logic [8:0]              mo,
  output logic signed [PCM_W-1:0] pcm
);
  logic signed [9:0]       conv;
  logic signed [ACC_W-1:0] conv_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [PCM_W-1:0] pcm_x;

  assign conv     = $signed({1'b0, mo}) - $signed({1'b0, DAC_ZERO});
  assign conv_ext = {{(ACC_W-10){conv[9]}}, conv};
  // Sum fits in 14 bits for a full period, so the <<2 never overflows 16 bits.
  assign pcm_x    = {acc_q, 2'b00};

  // Accumulator: a sync slot restarts the sum, other slots add to it.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC)       acc_q <= '0;
    else if (load) acc_q <= conv_ext;
    else if (add)  acc_q <= acc_q + conv_ext;
  end

`ifdef YM3438_DAC_LPF_EN
  logic signed [17:0] y_q, y_d, diff;

  assign diff = {{2{pcm_x[PCM_W-1]}}, pcm_x} - y_q;
  assign y_d  = y_q + (diff >>> 2);
  assign pcm  = y_d[PCM_W-1:0];

  // Filter state advances once per finished period.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC)      y_q <= '0;
    else if (fin) y_q <= y_d;
  end
`else
  assign pcm = pcm_x;
`endif
endmodule

// File: rtl/ym3438_dac_accum.sv
// YM3438 DAC accumulator: sums per-slot channel outputs over a sample period
// into 16-bit PCM and buffers {l,r} in a small FIFO.
// Optional output filter: define YM3438_DAC_LPF_EN.
module ym3438_dac_accum
  import ym3438_dac_pkg::*;
#(
  parameter int SLOTS      = 24,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    MCLK,
  input  logic                    IC,
  input  logic                    slot_en,
  input  logic                    sample_sync,
  input  logic [8:0]              MOL,
  input  logic [8:0]              MOR,
  input  logic                    pcm_ready,
  input  logic                    clr_flags,
  output logic                    pcm_valid,
  output logic signed [PCM_W-1:0] pcm_l,
  output logic signed [PCM_W-1:0] pcm_r,
  output logic                    slot_err,
  output logic                    ovf
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

  dac_state_e state_q, state_d;
  logic load, add, fin;
  logic [CNT_W-1:0] cnt_q;
  logic signed [PCM_W-1:0] ch_l, ch_r;

  pcm_sample_t mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] occ;
  logic full, pop, push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // State register.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) state_q <= SYNC_WAIT;
    else     state_q <= state_d;
  end

  // Slot decode: sync restarts a period, and in ACCUM also closes the old one.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    add     = 1'b0;
    fin     = 1'b0;
    if (slot_en) begin
      case (state_q)
        SYNC_WAIT: if (sample_sync) begin
          load    = 1'b1;
          state_d = ACCUM;
        end
        ACCUM: if (sample_sync) begin
          load = 1'b1;
          fin  = 1'b1;
        end else begin
          add = 1'b1;
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  // Slot counter, saturating so a runaway period still flags as wrong length.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC)                     cnt_q <= '0;
    else if (load)               cnt_q <= CNT_W'(1);
    else if (add && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  ym3438_dac_acc_ch u_ch_l (
    .MCLK (MCLK),
    .IC   (IC),
`ifdef YM3438_DAC_LPF_EN
    .fin  (fin),
`endif
    .load (load),
    .add  (add),
    .mo   (MOL),
    .pcm  (ch_l)
  );

  ym3438_dac_acc_ch u_ch_r (
    .MCLK (MCLK),
    .IC   (IC),
`ifdef YM3438_DAC_LPF_EN
    .fin  (fin),
`endif
    .load (load),
    .add  (add),
    .mo   (MOR),
    .pcm  (ch_r)
  );

  assign full      = (occ == OCC_W'(FIFO_DEPTH));
  assign pcm_valid = (occ != '0);
  assign pop       = pcm_valid & pcm_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = fin & (~full | pop);
  assign pcm_l     = mem[rd_ptr].l;
  assign pcm_r     = mem[rd_ptr].r;

  // Output FIFO storage and pointers.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= '{l: ch_l, r: ch_r};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky flags; a new event beats a same-cycle clear.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      slot_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (fin && cnt_q != SLOTS_C) slot_err <= 1'b1;
      else if (clr_flags)          slot_err <= 1'b0;
      if (fin && full && !pop)     ovf <= 1'b1;
      else if (clr_flags)          ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ym3438_dac_accum.sv
// Scoreboard bench for ym3438_dac_accum: directed periods push expected
// samples into a queue; a monitor pops and compares on every handshake.
module tb_ym3438_dac_accum;
  import ym3438_dac_pkg::*;

  logic MCLK = 1'b0;
  logic IC, slot_en, sample_sync, pcm_ready, clr_flags;
  logic [8:0] MOL, MOR;
  logic pcm_valid, slot_err, ovf;
  logic signed [PCM_W-1:0] pcm_l, pcm_r;

  pcm_sample_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic signed [17:0] yl = '0, yr = '0;

  always #5 MCLK = ~MCLK;

  ym3438_dac_accum #(.SLOTS(24), .FIFO_DEPTH(2)) dut (
    .MCLK(MCLK), .IC(IC), .slot_en(slot_en), .sample_sync(sample_sync),
    .MOL(MOL), .MOR(MOR), .pcm_ready(pcm_ready), .clr_flags(clr_flags),
    .pcm_valid(pcm_valid), .pcm_l(pcm_l), .pcm_r(pcm_r),
    .slot_err(slot_err), .ovf(ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected finished sum (already <<2); keep=0 means the FIFO drops it.
  task automatic exp_push(input int l, input int r, input bit keep);
    pcm_sample_t s;
`ifdef YM3438_DAC_LPF_EN
    yl = yl + (($signed(18'(l)) - yl) >>> 2);
    yr = yr + (($signed(18'(r)) - yr) >>> 2);
    s.l = yl[15:0];
    s.r = yr[15:0];
`else
    s.l = 16'(l);
    s.r = 16'(r);
`endif
    if (keep) q.push_back(s);
  endtask

  // One slot: slot_en for a cycle, then an idle cycle. Entered at posedge+1.
  task automatic slot(input logic [8:0] l, input logic [8:0] r, input bit sync, input bit rp);
    slot_en = 1'b1; sample_sync = sync; MOL = l; MOR = r;
    if (rp) pcm_ready = 1'b1;
    @(posedge MCLK); #1;
    slot_en = 1'b0; sample_sync = 1'b0;
    if (rp) pcm_ready = 1'b0;
    @(posedge MCLK); #1;
  endtask

  // A period of n slots: first slot (sync) carries l0/r0, the rest l/r.
  // A stray sample_sync without slot_en follows the first slot.
  task automatic period(input logic [8:0] l0, input logic [8:0] l, input logic [8:0] r0,
                        input logic [8:0] r, input int n, input bit rp);
    slot(l0, r0, 1'b1, rp);
    sample_sync = 1'b1;
    @(posedge MCLK); #1;
    sample_sync = 1'b0;
    for (int i = 1; i < n; i++) slot(l, r, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(posedge MCLK); #1;
    clr_flags = 1'b0;
  endtask

  // Monitor: every accepted sample must match the head of the queue.
  always @(negedge MCLK) begin
    if (IC && pcm_valid && pcm_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pop: got l=%0d r=%0d, expected no sample", pcm_l, pcm_r);
      end else begin
        pcm_sample_t e;
        e = q.pop_front();
        if (pcm_l !== e.l || pcm_r !== e.r) begin
          n_err++;
          $display("FAIL pcm: got l=%0d r=%0d, expected l=%0d r=%0d", pcm_l, pcm_r, e.l, e.r);
        end
      end
    end
  end

  initial begin
    #200000;
    n_cmp++; n_err++;
    $display("FAIL timeout: got no finish, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    IC = 1'b0; slot_en = 1'b0; sample_sync = 1'b0; pcm_ready = 1'b1; clr_flags = 1'b0;
    MOL = 9'h100; MOR = 9'h100;
    repeat (2) @(posedge MCLK);
    #1;
    chk("rst_valid", pcm_valid, 0);
    chk("rst_l", pcm_l, 0);
    chk("rst_r", pcm_r, 0);
    chk("rst_slot_err", slot_err, 0);
    chk("rst_ovf", ovf, 0);
    IC = 1'b1;
    @(posedge MCLK); #1;

    // Silence: first period only arms, then zeros come out.
    period(9'h100, 9'h100, 9'h100, 9'h100, 24, 0);
    exp_push(0, 0, 1);
    period(9'h100, 9'h100, 9'h100, 9'h100, 24, 0);
    exp_push(0, 0, 1);
    period(9'h100, 9'h100, 9'h100, 9'h100, 24, 0);

    // Full scale: left's sync slot is zero so the sum is 23*255 = 5865 -> 23460;
    // right is 24*-256 = -6144 -> -24576.
    exp_push(0, 0, 1);
    period(9'h100, 9'h1FF, 9'h000, 9'h000, 24, 0);
    exp_push(23460, -24576, 1);
    period(9'h100, 9'h1FF, 9'h000, 9'h000, 24, 0);
    chk("scale_slot_err", slot_err, 0);
    chk("scale_ovf", ovf, 0);

    // Short period of 20 slots of +/-32: 640 -> 2560.
    exp_push(23460, -24576, 1);
    period(9'h120, 9'h120, 9'h0E0, 9'h0E0, 20, 0);
    exp_push(2560, -2560, 1);
    period(9'h110, 9'h110, 9'h0F0, 9'h0F0, 24, 0);
    chk("short_slot_err", slot_err, 1);
    pulse_clr();
    chk("clr_slot_err", slot_err, 0);

    // Back-pressure: two samples held, the next two dropped.
    pcm_ready = 1'b0;
    exp_push(1536, -1536, 1);
    period(9'h101, 9'h101, 9'h100, 9'h100, 24, 0);
    chk("hold_valid", pcm_valid, 1);
    chk("hold_l0", pcm_l, q[0].l);
    exp_push(96, 0, 1);
    period(9'h102, 9'h102, 9'h100, 9'h100, 24, 0);
    exp_push(192, 0, 0);
    period(9'h103, 9'h103, 9'h100, 9'h100, 24, 0);
    chk("drop_ovf", ovf, 1);
    chk("hold_l1", pcm_l, q[0].l);
    chk("hold_r1", pcm_r, q[0].r);
    exp_push(288, 0, 0);
    period(9'h104, 9'h104, 9'h100, 9'h100, 24, 0);
    chk("hold_l2", pcm_l, q[0].l);
    pcm_ready = 1'b1;
    repeat (10) @(posedge MCLK);
    #1;
    chk("drain_valid", pcm_valid, 0);
    chk("drain_q", q.size(), 0);
    pulse_clr();
    chk("clr_ovf", ovf, 0);

    // Full FIFO with a push and a pop in the same cycle.
    pcm_ready = 1'b0;
    exp_push(384, 0, 1);
    period(9'h105, 9'h105, 9'h100, 9'h100, 24, 0);
    exp_push(480, 0, 1);
    period(9'h106, 9'h106, 9'h100, 9'h100, 24, 0);
    exp_push(576, 0, 1);
    period(9'h107, 9'h107, 9'h100, 9'h100, 24, 1);
    chk("pp_ovf", ovf, 0);
    chk("pp_valid", pcm_valid, 1);
    chk("pp_q", q.size(), 2);
    pcm_ready = 1'b1;
    repeat (10) @(posedge MCLK);
    #1;
    chk("pp_drain_valid", pcm_valid, 0);
    chk("pp_drain_q", q.size(), 0);

    // Reset mid-period: partial sum lost, first sync afterwards only arms.
    slot(9'h107, 9'h100, 1'b0, 1'b0);
    #2;
    IC = 1'b0;
    #1;
    chk("mid_rst_valid", pcm_valid, 0);
    chk("mid_rst_l", pcm_l, 0);
    chk("mid_rst_r", pcm_r, 0);
    chk("mid_rst_flags", {slot_err, ovf}, 0);
    yl = '0; yr = '0;
    @(posedge MCLK); #1;
    IC = 1'b1;
    @(posedge MCLK); #1;
    period(9'h108, 9'h108, 9'h100, 9'h100, 24, 0);
    chk("post_rst_valid", pcm_valid, 0);
    exp_push(768, 0, 1);
    period(9'h100, 9'h100, 9'h100, 9'h100, 24, 0);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge MCLK);
    #1;
    chk("final_q", q.size(), 0);
    chk("final_flags", {slot_err, ovf}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
